// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial NUM_BITS-wide adder with one full-adder stage and a registered carry.
// Define SIGNED_OVF_EN to add the registered signed-overflow output port.
module serial_adder_ctrl #(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] sum,
    output logic                carry_out
`ifdef SIGNED_OVF_EN
    ,
    output logic                overflow
`endif
);

    localparam int CNT_W = $clog2(NUM_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    state_t                state_r;
    state_t                next_state_s;
    logic [NUM_BITS-1:0]   a_sh_r;
    logic [NUM_BITS-1:0]   b_sh_r;
    // Holds the NUM_BITS-1 low sum bits; the final bit joins them on the last edge.
    logic [NUM_BITS-2:0]   s_sh_r;
    logic                  c_reg_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  load_s;
    logic                  shift_s;
    logic                  last_s;
    logic                  s_s;
    logic                  co_s;

    // Single full-adder stage on the current LSB pair and the stored carry
    always_comb begin
        s_s  = fa_sum(a_sh_r[0], b_sh_r[0], c_reg_r);
        co_s = fa_carry(a_sh_r[0], b_sh_r[0], c_reg_r);
    end

    // Next-state and datapath-enable decode
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        shift_s      = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_ADD;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ADD: begin
                shift_s = 1'b1;
                if (cnt_r == LAST_CNT) begin
                    last_s       = 1'b1;
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_ADD;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register with registered busy/done flags decoded from the next state
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy    <= (next_state_s == ST_ADD);
            done    <= (next_state_s == ST_DONE);
        end
    end

    // Operand shifters, carry register and bit counter
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            a_sh_r  <= {NUM_BITS{1'b0}};
            b_sh_r  <= {NUM_BITS{1'b0}};
            s_sh_r  <= {(NUM_BITS-1){1'b0}};
            c_reg_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (load_s) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            c_reg_r <= carry_in;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (shift_s) begin
            a_sh_r  <= a_sh_r >> 1;
            b_sh_r  <= b_sh_r >> 1;
            s_sh_r  <= (NUM_BITS-1)'({s_s, s_sh_r} >> 1);
            c_reg_r <= co_s;
            // Counter parks on the last index so it never wraps inside an operation
            cnt_r   <= last_s ? cnt_r : cnt_r + CNT_W'(1);
        end else begin
            a_sh_r  <= a_sh_r;
            b_sh_r  <= b_sh_r;
            s_sh_r  <= s_sh_r;
            c_reg_r <= c_reg_r;
            cnt_r   <= cnt_r;
        end
    end

    // Result registers update only on the last-bit edge, so partial sums never show
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sum       <= {NUM_BITS{1'b0}};
            carry_out <= 1'b0;
        end else if (last_s) begin
            sum       <= {s_s, s_sh_r};
            carry_out <= co_s;
        end else begin
            sum       <= sum;
            carry_out <= carry_out;
        end
    end

`ifdef SIGNED_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of the MSB
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            overflow <= 1'b0;
        end else if (last_s) begin
            overflow <= c_reg_r ^ co_s;
        end else begin
            overflow <= overflow;
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: self-checking bench for serial_adder_ctrl (8-bit instance plus a 4-bit instance).
// Overflow checks are compiled in when SIGNED_OVF_EN is defined.
module tb_serial_adder_ctrl;

    localparam int NB = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       carry_in;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       carry_out;
    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       cin4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;
`ifdef SIGNED_OVF_EN
    logic       overflow;
    logic       overflow4;
`endif

    int n_pass  = 0;
    int n_total = 0;
    logic [9:0] exp_q[$];
    vec_t vecs[6];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.NUM_BITS(NB)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .a(a), .b(b), .carry_in(carry_in),
        .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
`ifdef SIGNED_OVF_EN
        , .overflow(overflow)
`endif
    );

    serial_adder_ctrl #(.NUM_BITS(4)) dut4 (
        .clk(clk), .n_rst(n_rst), .start(start4), .a(a4), .b(b4), .carry_in(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .carry_out(cout4)
`ifdef SIGNED_OVF_EN
        , .overflow(overflow4)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Push the expectation, launch one add, scramble inputs after accept, then check at done.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          input logic [9:0] expv, input string tag);
        int cycles;
        int busy_cnt;
        logic sum_stable;
        logic [7:0] sum_before;
        logic [9:0] e;
        exp_q.push_back(expv);
        sum_before = sum;
        a = ta; b = tb; carry_in = tc; start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'($urandom_range(255));
        b = 8'($urandom_range(255));
        carry_in = 1'($urandom_range(1));
        cycles = 0; busy_cnt = 0; sum_stable = 1'b1;
        while (done !== 1'b1 && cycles < 40) begin
            if (busy === 1'b1) busy_cnt++;
            if (sum !== sum_before) sum_stable = 1'b0;
            tick();
            cycles++;
        end
        check({tag, " latency"}, 32'(cycles), 32'(NB));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(NB));
        check({tag, " sum_stable"}, 32'(sum_stable), 32'(1'b1));
        check({tag, " busy_at_done"}, 32'(busy), 32'(1'b0));
        if (exp_q.size() == 0) begin
            check({tag, " queue_empty"}, 32'(1'b0), 32'(1'b1));
        end else begin
            e = exp_q.pop_front();
            check({tag, " sum"}, 32'(sum), 32'(e[7:0]));
            check({tag, " carry_out"}, 32'(carry_out), 32'(e[8]));
`ifdef SIGNED_OVF_EN
            check({tag, " overflow"}, 32'(overflow), 32'(e[9]));
`endif
        end
        tick();
        check({tag, " done_one_cycle"}, 32'(done), 32'(1'b0));
    endtask

    initial begin
        int cycles;
        int busy_cnt;
        int done_cnt;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] r;
        logic [9:0] e;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};

        n_rst = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; carry_in = 1'b0;
        start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;

        // Reset state, then idle with start low
        tick();
        tick();
        check("rst busy", 32'(busy), 32'(1'b0));
        check("rst done", 32'(done), 32'(1'b0));
        check("rst sum", 32'(sum), 32'(8'h00));
        check("rst carry_out", 32'(carry_out), 32'(1'b0));
`ifdef SIGNED_OVF_EN
        check("rst overflow", 32'(overflow), 32'(1'b0));
`endif
        n_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle busy", 32'(busy), 32'(1'b0));
            check("idle done", 32'(done), 32'(1'b0));
            check("idle sum", 32'(sum), 32'(8'h00));
        end

        // Directed table
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin,
                   {vecs[i].exp_ovf, vecs[i].exp_cout, vecs[i].exp_sum}, $sformatf("vec%0d", i));
        end

        // Random vectors against an exact 9-bit reference sum
        for (int i = 0; i < 500; i++) begin
            ra = 8'($urandom_range(255));
            rb = 8'($urandom_range(255));
            rc = 1'($urandom_range(1));
            r  = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            e  = {(ra[7] == rb[7]) && (r[7] != ra[7]), r};
            run_op(ra, rb, rc, e, "rand");
        end

        // start during ADD (cycle 3) and DONE (cycle 9) is ignored
        exp_q.push_back({1'b0, 1'b0, 8'h07});
        a = 8'h03; b = 8'h04; carry_in = 1'b0; start = 1'b1;
        tick();
        done_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            start = (c == 3 || c == 9);
            a = start ? 8'hAA : 8'h03;
            b = start ? 8'h55 : 8'h04;
            tick();
            if (done === 1'b1) begin
                done_cnt++;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("ignore sum", 32'(sum), 32'(e[7:0]));
                    check("ignore carry_out", 32'(carry_out), 32'(e[8]));
                end else begin
                    check("ignore extra_done", 32'(1'b0), 32'(1'b1));
                end
            end
        end
        start = 1'b0;
        check("ignore done_count", 32'(done_cnt), 32'(1));
        check("ignore busy_end", 32'(busy), 32'(1'b0));

        // Reset asserted in the 4th busy cycle aborts the add
        a = 8'h12; b = 8'h34; carry_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 3; c++) tick();
        n_rst = 1'b0;
        tick();
        check("abort busy", 32'(busy), 32'(1'b0));
        check("abort sum", 32'(sum), 32'(8'h00));
        check("abort done", 32'(done), 32'(1'b0));
        check("abort carry_out", 32'(carry_out), 32'(1'b0));
        n_rst = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
        end
        check("abort no_activity", 32'(done_cnt), 32'(0));
        run_op(8'h01, 8'h01, 1'b0, {1'b0, 1'b0, 8'h02}, "after_abort");

        // 4-bit instance
        a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        cycles = 0; busy_cnt = 0;
        while (done4 !== 1'b1 && cycles < 40) begin
            if (busy4 === 1'b1) busy_cnt++;
            tick();
            cycles++;
        end
        check("nb4 latency", 32'(cycles), 32'(4));
        check("nb4 busy_cycles", 32'(busy_cnt), 32'(4));
        check("nb4 sum", 32'(sum4), 32'(4'h0));
        check("nb4 carry_out", 32'(cout4), 32'(1'b1));
        check("queue drained", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
